// File: rtl/txq_pkg.sv
// Shared definitions for the UART response queue: state encodings, entry layout
// and the error status codes the controller pushes as byte entries.
package txq_pkg;

   localparam int ENTRY_W = 33;

   localparam logic MODE_WORD = 1'b1;
   localparam logic MODE_BYTE = 1'b0;

   localparam logic [7:0] ERR_01 = 8'h01;
   localparam logic [7:0] ERR_02 = 8'h02;
   localparam logic [7:0] ERR_03 = 8'h03;

   // Externally visible state; S_START..S_STOP come from the frame serialiser.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP   = 3'd5
   } txq_state_e;

   // Byte sequencer inside the queue; SEQ_SEND covers a whole frame in flight.
   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_LOAD = 2'd1,
      SEQ_SEND = 2'd2
   } seq_state_e;

endpackage

// File: rtl/uart_tx_frame.sv
// Serialises one byte as start, 8 data bits LSB first, optional even parity, stop.
// Parity bit present only when TX_QUEUE_PARITY_EN is defined (8E1), else 8N1.
module uart_tx_frame
   import txq_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic [7:0] byte_i,
   output logic       serial_o,
   output logic       frame_done_o,
   output txq_state_e state_o
);

   localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

   txq_state_e       state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             ser_q, ser_d;
   logic             tick;
`ifdef TX_QUEUE_PARITY_EN
   logic             par_q, par_d;
`endif

   assign tick     = (tmr_q == TMR_LAST);
   assign serial_o = ser_q;
   assign state_o  = state_q;

   always_comb begin
      state_d      = state_q;
      tmr_d        = (state_q == S_IDLE || tick) ? '0 : tmr_q + TMR_W'(1);
      idx_d        = idx_q;
      shreg_d      = shreg_q;
      ser_d        = ser_q;
      frame_done_o = 1'b0;
`ifdef TX_QUEUE_PARITY_EN
      par_d        = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            ser_d = 1'b1;
            if (start_i) begin
               state_d = S_START;
               shreg_d = byte_i;
               ser_d   = 1'b0;
`ifdef TX_QUEUE_PARITY_EN
               par_d   = ^byte_i;
`endif
            end
         end
         S_START: begin
            if (tick) begin
               state_d = S_DATA;
               idx_d   = 3'd0;
               ser_d   = shreg_q[0];
            end
         end
         S_DATA: begin
            // The index wraps 7 -> 0 on the final data bit.
            if (tick) begin
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef TX_QUEUE_PARITY_EN
                  state_d = S_PARITY;
                  ser_d   = par_q;
`else
                  state_d = S_STOP;
                  ser_d   = 1'b1;
`endif
               end else begin
                  shreg_d = {1'b0, shreg_q[7:1]};
                  ser_d   = shreg_q[1];
               end
            end
         end
`ifdef TX_QUEUE_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               state_d = S_STOP;
               ser_d   = 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               state_d      = S_IDLE;
               frame_done_o = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            ser_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         ser_q   <= 1'b1;
`ifdef TX_QUEUE_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         ser_q   <= ser_d;
`ifdef TX_QUEUE_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: rtl/tx_response_queue.sv
// Response FIFO in front of the UART TX line; words go out MSB byte first.
// Build option TX_QUEUE_PARITY_EN adds an even-parity bit to every frame.
module tx_response_queue
   import txq_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4,
   parameter int PTR_W        = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_valid,
   input  logic        i_mode_select,
   input  logic [31:0] i_word,
   input  logic [7:0]  i_byte,
   output logic        o_ready,
   output logic        o_serial,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_overflow,
   output txq_state_e  o_dbg_state
);

   // Handshake: an entry is taken on a clock edge where i_valid && o_ready.
   // o_ready depends only on registered FIFO pointers, so a pop in the same
   // cycle never makes room for that cycle's push; i_valid while full drops
   // the entry and pulses o_overflow.

   logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
   logic               full, empty, push, pop;
   logic [ENTRY_W-1:0] head, wr_entry;

   seq_state_e         seq_q, seq_d;
   logic [31:0]        shift_q, shift_d;
   logic [2:0]         cnt_q, cnt_d;
   logic               done_q, ovf_q;
   logic               frame_start, frame_done;
   txq_state_e         frame_state;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign push     = i_valid && !full;
   assign pop      = (seq_q == SEQ_IDLE) && !empty;
   assign head     = mem_q[rd_ptr_q[PTR_W-1:0]];
   assign wr_entry = {i_mode_select, (i_mode_select == MODE_WORD) ? i_word : {24'h0, i_byte}};

   assign o_ready    = !full;
   assign o_busy     = !empty || (seq_q != SEQ_IDLE);
   assign o_done     = done_q;
   assign o_overflow = ovf_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_entry;
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Byte entries are left-aligned so every byte is taken from shift_q[31:24].
   always_comb begin
      seq_d       = seq_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      frame_start = 1'b0;
      case (seq_q)
         SEQ_IDLE: begin
            if (!empty) begin
               seq_d = SEQ_LOAD;
               if (head[ENTRY_W-1] == MODE_WORD) begin
                  shift_d = head[31:0];
                  cnt_d   = 3'd4;
               end else begin
                  shift_d = {head[7:0], 24'h0};
                  cnt_d   = 3'd1;
               end
            end
         end
         SEQ_LOAD: begin
            frame_start = 1'b1;
            seq_d       = SEQ_SEND;
            shift_d     = {shift_q[23:0], 8'h0};
            cnt_d       = cnt_q - 3'd1;
         end
         SEQ_SEND: begin
            if (frame_done) begin
               seq_d = (cnt_q != 3'd0) ? SEQ_LOAD : SEQ_IDLE;
            end
         end
         default: seq_d = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         seq_q   <= SEQ_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         seq_q   <= seq_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         done_q  <= (seq_q == SEQ_SEND) && frame_done && (cnt_q == 3'd0);
         ovf_q   <= i_valid && full;
      end
   end

   always_comb begin
      case (seq_q)
         SEQ_LOAD: o_dbg_state = S_LOAD;
         SEQ_SEND: o_dbg_state = frame_state;
         default:  o_dbg_state = S_IDLE;
      endcase
   end

   uart_tx_frame #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_frame (
      .clock_i      (clock),
      .reset_i      (reset),
      .start_i      (frame_start),
      .byte_i       (shift_q[31:24]),
      .serial_o     (o_serial),
      .frame_done_o (frame_done),
      .state_o      (frame_state)
   );

endmodule

// File: tb/tb_tx_response_queue.sv
// Directed bench for tx_response_queue: a UART line monitor decodes frames and
// checks them against an expected byte queue filled when entries are pushed.
module tb_tx_response_queue;
   import txq_pkg::*;

   localparam int CPB = 4;
`ifdef TX_QUEUE_PARITY_EN
   localparam int BITS = 11;
`else
   localparam int BITS = 10;
`endif
   localparam int FRAME_CYC = BITS * CPB;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_mode_select = 1'b0;
   logic [31:0] i_word = '0;
   logic [7:0]  i_byte = '0;
   logic        o_ready, o_serial, o_busy, o_done, o_overflow;
   txq_state_e  o_dbg_state;

   logic [7:0]  exp_q[$];
   int          start_cyc_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          done_cnt = 0;
   int          cyc = 0;
   int          epoch = 0;

   tx_response_queue #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4),
      .PTR_W        (2)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .i_valid       (i_valid),
      .i_mode_select (i_mode_select),
      .i_word        (i_word),
      .i_byte        (i_byte),
      .o_ready       (o_ready),
      .o_serial      (o_serial),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_overflow    (o_overflow),
      .o_dbg_state   (o_dbg_state)
   );

   // clock / reset bookkeeping
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge reset) epoch = epoch + 1;
   always @(negedge clock) if (o_done === 1'b1) done_cnt = done_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // line monitor / scoreboard
   initial begin : monitor
      logic       prev, start_lvl, stop_lvl, par_lvl;
      logic [7:0] d, e;
      int         ep;
      prev = 1'b1;
      par_lvl = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev = 1'b1;
         end else if (prev && !o_serial) begin
            ep = epoch;
            start_cyc_q.push_back(cyc);
            repeat (CPB / 2) @(negedge clock);
            start_lvl = o_serial;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clock);
               d[i] = o_serial;
            end
`ifdef TX_QUEUE_PARITY_EN
            repeat (CPB) @(negedge clock);
            par_lvl = o_serial;
`endif
            repeat (CPB) @(negedge clock);
            stop_lvl = o_serial;
            if (ep == epoch && !reset) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_byte: got %02h, expected no frame", d);
               end else begin
                  e = exp_q.pop_front();
                  check("start_bit", start_lvl, 1'b0);
                  check("tx_byte", d, e);
`ifdef TX_QUEUE_PARITY_EN
                  check("parity_bit", par_lvl, ^e);
`endif
                  check("stop_bit", stop_lvl, 1'b1);
               end
            end
            prev = o_serial;
         end else begin
            prev = o_serial;
         end
      end
   end

   // driver tasks (called at a negedge, return at the next negedge)
   task automatic drive(input logic mode, input logic [31:0] w, input logic [7:0] b,
                        input logic exp_acc);
      check("ready_before_push", o_ready, exp_acc);
      i_valid = 1'b1;
      i_mode_select = mode;
      i_word = w;
      i_byte = b;
      if (exp_acc) begin
         if (mode == MODE_WORD) begin
            exp_q.push_back(w[31:24]);
            exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
         end else begin
            exp_q.push_back(b);
         end
      end
      @(negedge clock);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (o_busy && k < budget) begin
         @(negedge clock);
         k++;
      end
      check("idle_in_time", o_busy, 1'b0);
      repeat (2) @(negedge clock);
      check("exp_drained", exp_q.size(), 0);
   endtask

   task automatic send_byte_timed(input logic [7:0] b);
      int k, d0;
      d0 = done_cnt;
      drive(MODE_BYTE, 32'h0, b, 1'b1);
      i_valid = 1'b0;
      check("line_high_push_edge", o_serial, 1'b1);
      @(negedge clock);
      check("line_high_pop_edge", o_serial, 1'b1);
      check("state_load", o_dbg_state, S_LOAD);
      check("busy_after_push", o_busy, 1'b1);
      @(negedge clock);
      check("start_latency", o_serial, 1'b0);
      k = 0;
      while (!o_done && k < 400) begin
         @(negedge clock);
         k++;
      end
      check("done_latency", k, FRAME_CYC);
      @(negedge clock);
      check("done_one_cycle", o_done, 1'b0);
      wait_idle(200);
      check("done_count_byte", done_cnt - d0, 1);
   endtask

   initial begin : watchdog
      #1000000;
      n_errors++;
      $display("FAIL global_timeout: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin : stimulus
      int d0;
      repeat (3) @(negedge clock);
      check("rst_serial", o_serial, 1'b1);
      check("rst_ready", o_ready, 1'b1);
      check("rst_busy", o_busy, 1'b0);
      check("rst_done", o_done, 1'b0);
      check("rst_overflow", o_overflow, 1'b0);
      check("rst_state", o_dbg_state, S_IDLE);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // single status byte with exact timing
      send_byte_timed(ERR_02);

      // word goes out MSB first with one LOAD cycle between bytes
      start_cyc_q.delete();
      d0 = done_cnt;
      drive(MODE_WORD, 32'hDEADBEEF, 8'h00, 1'b1);
      i_valid = 1'b0;
      wait_idle(1000);
      check("word_done_count", done_cnt - d0, 1);
      check("word_start_count", start_cyc_q.size(), 4);
      if (start_cyc_q.size() == 4) begin
         for (int i = 1; i < 4; i++) begin
            check("word_byte_gap", start_cyc_q[i] - start_cyc_q[i-1], FRAME_CYC + 1);
         end
      end

      // fill behind a word in flight, fifth push overflows
      d0 = done_cnt;
      drive(MODE_WORD, 32'h11223344, 8'h00, 1'b1);
      drive(MODE_BYTE, 32'h0, 8'hA1, 1'b1);
      drive(MODE_BYTE, 32'h0, 8'hA2, 1'b1);
      drive(MODE_BYTE, 32'h0, 8'hA3, 1'b1);
      drive(MODE_BYTE, 32'h0, 8'hA4, 1'b1);
      drive(MODE_BYTE, 32'h0, 8'hA5, 1'b0);
      check("overflow_pulse", o_overflow, 1'b1);
      i_valid = 1'b0;
      @(negedge clock);
      check("overflow_one_cycle", o_overflow, 1'b0);
      wait_idle(3000);
      check("fill_done_count", done_cnt - d0, 5);

      // push into a queue holding 3 while transmitting
      d0 = done_cnt;
      drive(MODE_WORD, 32'h55667788, 8'h00, 1'b1);
      drive(MODE_BYTE, 32'h0, 8'hB1, 1'b1);
      drive(MODE_BYTE, 32'h0, 8'hB2, 1'b1);
      drive(MODE_BYTE, 32'h0, ERR_03, 1'b1);
      i_valid = 1'b0;
      repeat (20) @(negedge clock);
      check("busy_holding_three", o_busy, 1'b1);
      drive(MODE_BYTE, 32'h0, 8'hB4, 1'b1);
      i_valid = 1'b0;
      check("ready_after_fourth", o_ready, 1'b0);
      wait_idle(3000);
      check("order_done_count", done_cnt - d0, 5);

      // reset in the middle of a data bit
      drive(MODE_WORD, 32'hCAFEF00D, 8'h00, 1'b1);
      i_valid = 1'b0;
      repeat (8) @(negedge clock);
      check("mid_data_state", o_dbg_state, S_DATA);
      d0 = done_cnt;
      reset = 1'b1;
      #1;
      check("rst_mid_serial", o_serial, 1'b1);
      check("rst_mid_busy", o_busy, 1'b0);
      check("rst_mid_ready", o_ready, 1'b1);
      exp_q.delete();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (50) @(negedge clock);
      check("rst_no_done", done_cnt - d0, 0);
      check("rst_line_idle", o_serial, 1'b1);
      send_byte_timed(ERR_01);

      // parity-sensitive bytes (even parity 0 and 1)
      send_byte_timed(8'h03);
      send_byte_timed(8'h07);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
